// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory bus between instruction fetch and data
// access. Data wins by default, but a pending fetch is guaranteed a grant after
// STARVE_LIMIT consecutive data grants. Every transaction is IDLE -> GRANT_x ->
// IDLE, which leaves one bubble cycle between accesses.
module mem_access_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        state, next;
  logic [SW-1:0] streak;
  logic          fetch_ok, d_req;

  // halt only gates new fetch grants; a fetch already granted runs to completion
  assign fetch_ok = i_ren & ~halt;
  assign d_req    = d_ren | d_wen;

  // read data is a plain pass-through; requesters qualify it with their busy
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // state register; async reset abandons any in-flight access
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

  // starvation counter: counts data grants that overtook an eligible fetch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      streak <= '0;
    else if (!fetch_ok)
      streak <= '0;
    else if (state == IDLE && next == GRANT_I)
      streak <= '0;
    else if (state == IDLE && next == GRANT_D && streak != LIMIT)
      streak <= streak + 1'b1;
  end

  // arbitration in IDLE; grants release unconditionally on completion
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (d_req && (streak < LIMIT || !fetch_ok)) next = GRANT_D;
        else if (fetch_ok)                          next = GRANT_I;
      end
      GRANT_I, GRANT_D: if (!m_busy) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // bus drive and completion pulses; m_* never depend on m_busy
  always_comb begin
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_byte_en = '0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    case (state)
      GRANT_I: begin
        m_ren     = 1'b1;
        m_addr    = i_addr;
        m_byte_en = 4'hF;
        i_busy    = m_busy;
      end
      GRANT_D: begin
        m_wen     = d_wen;
        m_ren     = d_ren & ~d_wen;   // write wins if both strobes are set
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_byte_en = d_byte_en;
        d_busy    = m_busy;
      end
      default: ;
    endcase
  end

endmodule
